// File: rtl/spn_pkg.sv
// -----------------------------------------------------------------------------
// spn_pkg
// Shared types and helpers for the spn_stride lane permuter.
//   mode_e      : permutation applied to a frame while it drains.
//   decode_mode : maps the raw 2-bit mode input onto mode_e (code 3 -> bypass).
//   bitrev      : reverses the low nbits bits of a lane index (nbits <= 6).
// -----------------------------------------------------------------------------
package spn_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS    = 2'd0,
    MODE_TRANSPOSE = 2'd1,
    MODE_BITREV    = 2'd2
  } mode_e;

  // Widest lane index supported (PARA up to 64).
  localparam int MAX_IDX_BITS = 6;

  function automatic logic [MAX_IDX_BITS-1:0] bitrev(
    input logic [MAX_IDX_BITS-1:0] idx,
    input int                      nbits
  );
    logic [MAX_IDX_BITS-1:0] r;
    r = '0;
    // Shift the low bits of idx in LSB-first; after nbits steps the first
    // bit taken (idx[0]) sits at position nbits-1.
    for (int b = 0; b < MAX_IDX_BITS; b++) begin
      if (b < nbits) r = {r[MAX_IDX_BITS-2:0], idx[b]};
    end
    return r;
  endfunction

  function automatic mode_e decode_mode(input logic [1:0] raw);
    mode_e m;
    case (raw)
      2'd1:    m = MODE_TRANSPOSE;
      2'd2:    m = MODE_BITREV;
      default: m = MODE_BYPASS;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/spn_bank.sv
// -----------------------------------------------------------------------------
// spn_bank
// PARA x PARA word store used as one half of the ping-pong buffer.
//   clk      : write clock
//   wr_en    : write wr_data into row wr_row this cycle
//   wr_row   : row (beat index within the frame) being written
//   wr_data  : PARA lane words of the incoming beat
//   rd_mode  : read shape: row (bypass), column (transpose), bit-reversed row
//   rd_idx   : output beat index being read
//   rd_data  : PARA lane words for that output beat (combinational)
// -----------------------------------------------------------------------------
module spn_bank
  import spn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PARA       = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(PARA)-1:0]  wr_row,
  input  logic [DATA_WIDTH-1:0]    wr_data [PARA],
  input  mode_e                    rd_mode,
  input  logic [$clog2(PARA)-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0]    rd_data [PARA]
);

  localparam int AW = $clog2(PARA);

  logic [DATA_WIDTH-1:0] mem_q [PARA][PARA];

  // NOTE: the array is deliberately left without a reset; a row is always
  // written before the drain logic can read it, and skipping the reset keeps
  // it mappable to plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < PARA; i++) mem_q[wr_row][i] <= wr_data[i];
    end
  end

  always_comb begin
    for (int i = 0; i < PARA; i++) begin
      logic [AW-1:0] lane;
      logic [AW-1:0] lane_rev;
      lane     = AW'(i);
      lane_rev = AW'(bitrev(MAX_IDX_BITS'(i), AW));
      case (rd_mode)
        MODE_TRANSPOSE: rd_data[i] = mem_q[lane][rd_idx];
        MODE_BITREV:    rd_data[i] = mem_q[rd_idx][lane_rev];
        default:        rd_data[i] = mem_q[rd_idx][lane];
      endcase
    end
  end

endmodule

// File: rtl/spn_stride.sv
// -----------------------------------------------------------------------------
// spn_stride
// Streaming PARA-lane permuter. Collects PARA valid beats into one bank while
// the other bank drains the previous frame, permuted by the frame's mode.
//   clk           : clock, rising edge
//   rst           : asynchronous reset, active low
//   valid_in      : input_stream carries a beat
//   input_stream  : PARA lane words, index 0 = lane 0
//   mode          : 0 bypass, 1 transpose, 2 lane bit-reverse, 3 bypass;
//                   sampled on the frame's first beat only
//   valid_out     : output_stream carries a beat (PARA contiguous per frame)
//   output_stream : permuted lane words (registered, holds when idle)
//   last_out      : final beat of a drained frame
// -----------------------------------------------------------------------------
module spn_stride
  import spn_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PARA       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [DATA_WIDTH-1:0]  input_stream [PARA],
  input  logic [1:0]             mode,
  output logic                   valid_out,
  output logic [DATA_WIDTH-1:0]  output_stream [PARA],
  output logic                   last_out
);

  localparam int            AW       = $clog2(PARA);
  localparam logic [AW-1:0] LAST_IDX = AW'(PARA - 1);
  localparam logic [AW-1:0] ONE      = AW'(1);

  logic [AW-1:0]         in_cnt_q,       in_cnt_d;
  logic [AW-1:0]         out_cnt_q,      out_cnt_d;
  logic                  fill_sel_q,     fill_sel_d;     // bank receiving beats
  logic                  drain_active_q, drain_active_d;
  mode_e                 mode_q,         mode_d;         // mode of frame being filled
  mode_e                 drain_mode_q,   drain_mode_d;   // mode of frame being drained
  logic                  valid_out_q,    valid_out_d;
  logic                  last_out_q,     last_out_d;
  logic [DATA_WIDTH-1:0] output_stream_q [PARA];
  logic [DATA_WIDTH-1:0] output_stream_d [PARA];

  logic                  frame_done;
  logic                  wr_en0, wr_en1;
  logic [DATA_WIDTH-1:0] rd_data0   [PARA];
  logic [DATA_WIDTH-1:0] rd_data1   [PARA];
  logic [DATA_WIDTH-1:0] drain_data [PARA];

  assign frame_done = valid_in && (in_cnt_q == LAST_IDX);
  assign wr_en0     = valid_in && !fill_sel_q;
  assign wr_en1     = valid_in &&  fill_sel_q;

  spn_bank #(.DATA_WIDTH(DATA_WIDTH), .PARA(PARA)) u_bank0 (
    .clk     (clk),
    .wr_en   (wr_en0),
    .wr_row  (in_cnt_q),
    .wr_data (input_stream),
    .rd_mode (drain_mode_q),
    .rd_idx  (out_cnt_q),
    .rd_data (rd_data0)
  );

  spn_bank #(.DATA_WIDTH(DATA_WIDTH), .PARA(PARA)) u_bank1 (
    .clk     (clk),
    .wr_en   (wr_en1),
    .wr_row  (in_cnt_q),
    .wr_data (input_stream),
    .rd_mode (drain_mode_q),
    .rd_idx  (out_cnt_q),
    .rd_data (rd_data1)
  );

  // The drain bank is always the one not being filled.
  always_comb begin
    for (int i = 0; i < PARA; i++) drain_data[i] = fill_sel_q ? rd_data0[i] : rd_data1[i];
  end

  always_comb begin
    // NOTE: every combinational output is given a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    in_cnt_d        = in_cnt_q;
    out_cnt_d       = out_cnt_q;
    fill_sel_d      = fill_sel_q;
    drain_active_d  = drain_active_q;
    mode_d          = mode_q;
    drain_mode_d    = drain_mode_q;
    valid_out_d     = 1'b0;
    last_out_d      = 1'b0;
    output_stream_d = output_stream_q;

    if (valid_in) begin
      if (in_cnt_q == '0) mode_d = decode_mode(mode);
      in_cnt_d = in_cnt_q + ONE;  // wraps to 0 after PARA-1
    end

    if (drain_active_q) begin
      valid_out_d = 1'b1;
      last_out_d  = (out_cnt_q == LAST_IDX);
      for (int i = 0; i < PARA; i++) output_stream_d[i] = drain_data[i];
      out_cnt_d = out_cnt_q + ONE;
      if (out_cnt_q == LAST_IDX) drain_active_d = 1'b0;
    end

    // A swap can coincide with the final drain beat of the previous frame
    // (back-to-back input); the new drain then continues without a gap.
    // mode_q already holds this frame's mode because PARA >= 2 means the
    // final beat is never beat 0.
    if (frame_done) begin
      fill_sel_d     = !fill_sel_q;
      drain_active_d = 1'b1;
      out_cnt_d      = '0;
      drain_mode_d   = mode_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      fill_sel_q     <= 1'b0;
      drain_active_q <= 1'b0;
      mode_q         <= MODE_BYPASS;
      drain_mode_q   <= MODE_BYPASS;
      valid_out_q    <= 1'b0;
      last_out_q     <= 1'b0;
      for (int i = 0; i < PARA; i++) output_stream_q[i] <= '0;
    end else begin
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      fill_sel_q     <= fill_sel_d;
      drain_active_q <= drain_active_d;
      mode_q         <= mode_d;
      drain_mode_q   <= drain_mode_d;
      valid_out_q    <= valid_out_d;
      last_out_q     <= last_out_d;
      for (int i = 0; i < PARA; i++) output_stream_q[i] <= output_stream_d[i];
    end
  end

  assign valid_out     = valid_out_q;
  assign last_out      = last_out_q;
  assign output_stream = output_stream_q;

endmodule
